// File: rtl/n1_pf_if.sv
`default_nettype none
// =====================================================================
// n1_pf_if -- program-bus, flow-control and IR-side signals of n1_pf.
// Rev 1.0
// =====================================================================
interface n1_pf_if #(
  parameter int PBUS_AW = 14,
  parameter int PBUS_DW = 16
);
  logic               pbus_cyc_o;
  logic               pbus_stb_o;
  logic [PBUS_AW-1:0] pbus_adr_o;
  logic               pbus_ack_i;
  logic               pbus_err_i;
  logic               pbus_stall_i;
  logic [PBUS_DW-1:0] pbus_dat_i;
  logic               fc2pf_redirect_i;
  logic [PBUS_AW-1:0] fc2pf_target_i;
  logic               fc2pf_hold_i;
  logic               pf2ir_valid_o;
  logic [PBUS_DW-1:0] pf2ir_dat_o;
  logic [PBUS_AW-1:0] pf2ir_adr_o;
  logic               ir2pf_ready_i;
  logic               pf2excpt_buserr_o;

  modport master (
    output pbus_cyc_o, pbus_stb_o, pbus_adr_o,
    input  pbus_ack_i, pbus_err_i, pbus_stall_i, pbus_dat_i,
    input  fc2pf_redirect_i, fc2pf_target_i, fc2pf_hold_i,
    output pf2ir_valid_o, pf2ir_dat_o, pf2ir_adr_o,
    input  ir2pf_ready_i,
    output pf2excpt_buserr_o
  );

  modport slave (
    input  pbus_cyc_o, pbus_stb_o, pbus_adr_o,
    output pbus_ack_i, pbus_err_i, pbus_stall_i, pbus_dat_i,
    output fc2pf_redirect_i, fc2pf_target_i, fc2pf_hold_i,
    input  pf2ir_valid_o, pf2ir_dat_o, pf2ir_adr_o,
    output ir2pf_ready_i,
    input  pf2excpt_buserr_o
  );
endinterface
`default_nettype wire

// File: rtl/n1_pf.sv
`default_nettype none
// =====================================================================
// n1_pf -- N1 program-bus prefetcher: pipelined Wishbone reads into a
// DEPTH-entry word/address FIFO. Optional macro: N1_PF_ABORT_EN. Rev 1.0
// =====================================================================
module n1_pf #(
  parameter int                 PBUS_AW = 14,
  parameter int                 PBUS_DW = 16,
  parameter int                 DEPTH   = 4,
  parameter logic [PBUS_AW-1:0] RST_ADR = '0,
  localparam int                LW      = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          async_rst_i,
  n1_pf_if.master       bus,
  output logic [1:0]    prb_pf_state_o,
  output logic [LW-1:0] prb_pf_level_o
);
  localparam int PW  = $clog2(DEPTH);
  // Back-to-back redirects can stack discards beyond DEPTH, so give headroom.
  localparam int DCW = LW + 4;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_DRAIN = 2'b01,
    S_ABORT = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [PBUS_AW-1:0] adr_q, adr_d;
  logic [PBUS_AW-1:0] rsp_adr_q, rsp_adr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [LW-1:0]      out_q, out_d;
  logic [DCW-1:0]     disc_q, disc_d;
  logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic               shold_q, shold_d;
  logic               buserr_q, buserr_d;
  logic [PBUS_DW-1:0] dat_mem_q [DEPTH];
  logic [PBUS_AW-1:0] adr_mem_q [DEPTH];

  logic w_active, w_room, w_stb, w_acc, w_rsp, w_disc;
  logic w_push, w_bad, w_valid, w_pop;

  assign w_active = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign w_room   = ({1'b0, level_q} + {1'b0, out_q}) < (LW+1)'(DEPTH);
  // shold_q keeps a stalled request on the bus even if hold rises meanwhile.
  assign w_stb    = async_rst_i && w_active &&
                    (shold_q || (!bus.fc2pf_hold_i && w_room));
  assign w_acc    = w_stb && !bus.pbus_stall_i;
  assign w_rsp    = w_active && (bus.pbus_ack_i || bus.pbus_err_i);
  assign w_disc   = (disc_q != '0);
  assign w_push   = w_rsp && bus.pbus_ack_i && !w_disc && !bus.fc2pf_redirect_i;
  assign w_bad    = w_rsp && bus.pbus_err_i && !w_disc && !bus.fc2pf_redirect_i;
  assign w_valid  = (level_q != '0);
  assign w_pop    = w_valid && bus.ir2pf_ready_i;

  always_comb begin
    state_d   = state_q;
    adr_d     = w_acc ? adr_q + PBUS_AW'(1) : adr_q;
    rsp_adr_d = w_push ? rsp_adr_q + PBUS_AW'(1) : rsp_adr_q;
    level_d   = level_q + LW'(w_push) - LW'(w_pop);
    out_d     = out_q + LW'(w_acc) - LW'(w_rsp && !w_disc);
    disc_d    = disc_q - DCW'(w_rsp && w_disc);
    rd_d      = rd_q + PW'(w_pop);
    wr_d      = wr_q + PW'(w_push);
    shold_d   = w_stb && bus.pbus_stall_i && !bus.fc2pf_redirect_i;
    buserr_d  = w_bad;

    if (state_q == S_DRAIN && disc_d == '0) state_d = S_FETCH;
    if (state_q == S_ABORT)                 state_d = S_FETCH;
    if (w_bad) begin
      state_d = S_ERROR;
      out_d   = '0;
    end

    if (bus.fc2pf_redirect_i) begin
      adr_d     = bus.fc2pf_target_i;
      rsp_adr_d = bus.fc2pf_target_i;
      level_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
`ifdef N1_PF_ABORT_EN
      out_d     = '0;
      disc_d    = '0;
      // From ERROR the bus cycle is already closed, so no abort cycle is needed.
      state_d   = (state_q == S_ERROR) ? S_FETCH : S_ABORT;
`else
      // Everything still in flight, including a request accepted right now,
      // belongs to the old stream and must be dropped.
      disc_d    = disc_q + DCW'(out_q) + DCW'(w_acc) - DCW'(w_rsp);
      out_d     = '0;
      state_d   = (disc_d != '0) ? S_DRAIN : S_FETCH;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q   <= S_FETCH;
      adr_q     <= RST_ADR;
      rsp_adr_q <= RST_ADR;
      level_q   <= '0;
      out_q     <= '0;
      disc_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      shold_q   <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      rsp_adr_q <= rsp_adr_d;
      level_q   <= level_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      shold_q   <= shold_d;
      buserr_q  <= buserr_d;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        dat_mem_q[i] <= '0;
        adr_mem_q[i] <= '0;
      end
    end else if (w_push) begin
      dat_mem_q[wr_q] <= bus.pbus_dat_i;
      adr_mem_q[wr_q] <= rsp_adr_q;
    end
  end

  assign bus.pbus_cyc_o        = w_active && (w_stb || (out_q != '0) || w_disc);
  assign bus.pbus_stb_o        = w_stb;
  assign bus.pbus_adr_o        = adr_q;
  assign bus.pf2ir_valid_o     = w_valid;
  assign bus.pf2ir_dat_o       = dat_mem_q[rd_q];
  assign bus.pf2ir_adr_o       = adr_mem_q[rd_q];
  assign bus.pf2excpt_buserr_o = buserr_q;
  assign prb_pf_state_o        = state_q;
  assign prb_pf_level_o        = level_q;
endmodule
`default_nettype wire

// File: tb/tb_n1_pf.sv
`default_nettype none
// =====================================================================
// tb_n1_pf -- randomized bench for n1_pf against a transaction-level
// model (epoch-tagged request queue, word queue). Rev 1.0
// =====================================================================
module tb_n1_pf;
  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RST = 14'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    st;
  logic [LW-1:0] lvl;

  n1_pf_if #(.PBUS_AW(AW), .PBUS_DW(DW)) bus ();

  n1_pf #(.PBUS_AW(AW), .PBUS_DW(DW), .DEPTH(DEPTH), .RST_ADR(RST)) dut (
    .clk_i          (clk),
    .async_rst_i    (rst_n),
    .bus            (bus),
    .prb_pf_state_o (st),
    .prb_pf_level_o (lvl)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] adr; int ep; } req_t;
  typedef struct { logic [DW-1:0] dat; logic [AW-1:0] adr; } word_t;

  req_t    sq[$];          // requests on the bus awaiting a response
  word_t   fq[$];          // words the IR stage should see, in order
  int      epoch;
  logic [AW-1:0] m_req;    // next address the prefetcher should request
  bit      m_shold, m_err, m_abort, m_buserr;
  int      vectors, miscompares;
  int      p_stall, p_ready, p_hold, p_ack, p_err, p_redir;

  function automatic logic [DW-1:0] memw(input logic [AW-1:0] a);
    logic [31:0] t;
    t = (32'(a) * 32'd40503) ^ 32'h0000_5A5A;
    return t[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    fq.delete();
    epoch++;
    m_req    = RST;
    m_shold  = 1'b0;
    m_err    = 1'b0;
    m_abort  = 1'b0;
    m_buserr = 1'b0;
  endtask

  // One clock: entered and left at a falling edge.
  task automatic step(input bit frc, input logic [AW-1:0] ftgt);
    bit redir, hold, ready, stall, rsp, err, e_stb, e_cyc, was_err;
    logic [AW-1:0] tgt;
    logic [1:0] e_st;
    int cur, old;
    req_t h;
    redir = frc || ($urandom_range(0, 999) < p_redir);
    tgt   = frc ? ftgt : AW'($urandom);
    hold  = $urandom_range(0, 99) < p_hold;
    ready = $urandom_range(0, 99) < p_ready;
    stall = $urandom_range(0, 99) < p_stall;
    cur = 0;
    foreach (sq[i]) if (sq[i].ep == epoch) cur++;
    old = sq.size() - cur;
    e_stb = !m_abort && !m_err && (m_shold || (!hold && (fq.size() + cur < DEPTH)));
    e_cyc = !m_abort && !m_err && (e_stb || sq.size() != 0);
`ifdef N1_PF_ABORT_EN
    e_st = m_abort ? 2'b10 : (m_err ? 2'b11 : 2'b00);
`else
    e_st = m_err ? 2'b11 : ((old != 0) ? 2'b01 : 2'b00);
`endif
    if (!e_cyc) sq.delete();
    rsp = (sq.size() != 0) && ($urandom_range(0, 99) < p_ack);
    err = rsp && ($urandom_range(0, 999) < p_err);

    bus.fc2pf_redirect_i = redir;
    bus.fc2pf_target_i   = tgt;
    bus.fc2pf_hold_i     = hold;
    bus.ir2pf_ready_i    = ready;
    bus.pbus_stall_i     = stall;
    bus.pbus_ack_i       = rsp && !err;
    bus.pbus_err_i       = err;
    bus.pbus_dat_i       = rsp ? memw(sq[0].adr) : DW'($urandom);
    #1;
    chk("cyc", bus.pbus_cyc_o, e_cyc);
    chk("stb", bus.pbus_stb_o, e_stb);
    if (e_stb) chk("req_adr", bus.pbus_adr_o, m_req);
    chk("valid", bus.pf2ir_valid_o, fq.size() != 0);
    if (fq.size() != 0) begin
      chk("head_adr", bus.pf2ir_adr_o, fq[0].adr);
      chk("head_dat", bus.pf2ir_dat_o, fq[0].dat);
    end
    chk("level", lvl, fq.size());
    chk("state", st, e_st);
    chk("buserr", bus.pf2excpt_buserr_o, m_buserr);

    if (fq.size() != 0 && ready) void'(fq.pop_front());
    if (e_stb && !stall) begin
      sq.push_back('{adr: m_req, ep: epoch});
      m_req = m_req + AW'(1);
    end
    m_shold  = e_stb && stall && !redir;
    m_buserr = 1'b0;
    was_err  = m_err;
    if (redir) begin
      epoch++;
      fq.delete();
      m_req = tgt;
      m_err = 1'b0;
`ifdef N1_PF_ABORT_EN
      m_abort = !was_err;
    end else begin
      m_abort = 1'b0;
`endif
    end
    if (rsp) begin
      h = sq.pop_front();
      if (h.ep == epoch) begin
        if (err) begin
          m_err    = 1'b1;
          m_buserr = 1'b1;
        end else begin
          fq.push_back('{dat: memw(h.adr), adr: h.adr});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cyc", bus.pbus_cyc_o, 1'b0);
    chk("rst_stb", bus.pbus_stb_o, 1'b0);
    chk("rst_adr", bus.pbus_adr_o, RST);
    chk("rst_valid", bus.pf2ir_valid_o, 1'b0);
    chk("rst_buserr", bus.pf2excpt_buserr_o, 1'b0);
    chk("rst_level", lvl, 0);
    chk("rst_state", st, 2'b00);
  endtask

  initial begin
    bus.fc2pf_redirect_i = 1'b0;
    bus.fc2pf_target_i   = '0;
    bus.fc2pf_hold_i     = 1'b0;
    bus.ir2pf_ready_i    = 1'b0;
    bus.pbus_stall_i     = 1'b0;
    bus.pbus_ack_i       = 1'b0;
    bus.pbus_err_i       = 1'b0;
    bus.pbus_dat_i       = '0;
    vectors = 0;
    miscompares = 0;
    epoch = 0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs();
    chk("rst_head_dat", bus.pf2ir_dat_o, 16'h0000);
    chk("rst_head_adr", bus.pf2ir_adr_o, 14'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // streaming: no stall, immediate acks, IR always ready
    p_stall = 0; p_ready = 100; p_hold = 0; p_ack = 100; p_err = 0; p_redir = 0;
    repeat (30) step(1'b0, '0);

    // backpressure: buffer fills, then a single pop frees one slot
    p_ready = 0;
    repeat (12) step(1'b0, '0);
    p_ready = 100;
    step(1'b0, '0);
    p_ready = 0;
    repeat (4) step(1'b0, '0);

    // stall: request held for three cycles
    p_ready = 100; p_stall = 100;
    repeat (3) step(1'b0, '0);
    p_stall = 0;
    repeat (6) step(1'b0, '0);

    // redirect with requests still in flight
    p_ack = 0;
    repeat (2) step(1'b0, '0);
    step(1'b1, 14'h0100);
    p_ack = 100;
    repeat (15) step(1'b0, '0);

    // bus error on the third response, words kept until redirect
    p_ack = 0; p_ready = 0;
    repeat (4) step(1'b0, '0);
    p_ack = 100;
    repeat (2) step(1'b0, '0);
    p_err = 1000;
    step(1'b0, '0);
    p_err = 0;
    repeat (6) step(1'b0, '0);
    p_ready = 100;
    repeat (3) step(1'b0, '0);
    step(1'b1, 14'h0020);
    repeat (10) step(1'b0, '0);

    // address wrap-around
    step(1'b1, 14'h3FFF);
    repeat (12) step(1'b0, '0);

    // random mix of everything
    p_stall = 30; p_ready = 60; p_hold = 10; p_ack = 50; p_err = 5; p_redir = 20;
    repeat (3000) step(1'b0, '0);

    // asynchronous reset in the middle of traffic
    #2;
    rst_n = 1'b0;
    bus.pbus_ack_i = 1'b0;
    bus.pbus_err_i = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (300) step(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/n1_pf.md
# n1_pf

Parametrised program-bus prefetcher for the N1 core: issues pipelined Wishbone reads ahead of execution and buffers up to `DEPTH` instruction words with their addresses for the IR stage. Sits between the program bus and the IR and flow-control logic. It generalises single-access flow-control fetching to configurable width and depth with multiple outstanding requests. Redirects are taken from flow control; bus errors are reported to the exception logic.

## Interface
Parameters:
- `PBUS_AW`, 14: program address width (word addresses).
- `PBUS_DW`, 16: instruction word width.
- `DEPTH`, 4: buffer depth; power of two, ≥2. It also bounds in-flight requests.
- `RST_ADR`, 0: first fetch address after reset.

Ports (`LW` = `$clog2(DEPTH)+1`):
- `clk_i` in 1: module clock.
- `async_rst_i` in 1: asynchronous reset, active-low.
- `pbus_cyc_o` out 1: bus cycle indicator.
- `pbus_stb_o` out 1: read request.
- `pbus_adr_o` out `PBUS_AW`: request address.
- `pbus_ack_i` in 1: read data valid.
- `pbus_err_i` in 1: bus error response.
- `pbus_stall_i` in 1: request not accepted.
- `pbus_dat_i` in `PBUS_DW`: read data.
- `fc2pf_redirect_i` in 1: flush and refetch from the target.
- `fc2pf_target_i` in `PBUS_AW`: redirect address.
- `fc2pf_hold_i` in 1: suppress new requests.
- `pf2ir_valid_o` out 1: head word valid.
- `pf2ir_dat_o` out `PBUS_DW`: head word.
- `pf2ir_adr_o` out `PBUS_AW`: head word address.
- `ir2pf_ready_i` in 1: IR consumes the head word.
- `pf2excpt_buserr_o` out 1: one-cycle bus error pulse.
- `prb_pf_state_o` out 2: state.
- `prb_pf_level_o` out `LW`: buffer fill level.

## Operation
- State encoding: FETCH=00, DRAIN=01, ABORT=10, ERROR=11.
- Reset state: FETCH.
- Reset values:
  - `pbus_cyc_o`, `pbus_stb_o`, `pf2ir_valid_o`, `pf2excpt_buserr_o` = 0.
  - `pbus_adr_o` = `RST_ADR`.
  - Level, outstanding and discard counters = 0.
  - `pf2ir_dat_o` and `pf2ir_adr_o` = 0.
- Issue rule: `pbus_stb_o` asserts when state is FETCH or DRAIN, `fc2pf_hold_i`=0, and level + outstanding < `DEPTH`.
- Request acceptance: a request is accepted when `stb & !stall`. On acceptance, outstanding +1 and `pbus_adr_o` +1, wrapping modulo 2^`PBUS_AW`.
- While stalled, `stb` and `adr` are held stable. The only exceptions are redirect and abort.
- `pbus_cyc_o` = `stb` | (outstanding≠0) | (discard≠0), except in ABORT and ERROR, where it is 0.
- Response handling:
  - A response is ack or err.
  - Each response decrements discard if discard≠0, otherwise decrements outstanding.
  - A non-discarded ack pushes {`pbus_dat_i`, request address} into the FIFO.
- Consumption: `valid & ready` pops the head. Simultaneous push and pop leaves the level unchanged. A push while full cannot occur, because the issue rule prevents it.
- Redirect:
  - Flushes the FIFO, so `valid` = 0 next cycle. A pop in the same cycle completes first.
  - Loads `pbus_adr_o` with `fc2pf_target_i`.
  - Any ack in the same cycle is discarded.
  - Mode-dependent handling is described under Configuration.
- Non-discarded err:
  - `pf2excpt_buserr_o` pulses one cycle.
  - State goes to ERROR.
  - `cyc` and `stb` drop and outstanding clears.
  - FIFO entries are preserved and remain readable.
- ERROR is left only by redirect. A redirect takes priority over a same-cycle err.
- DRAIN → FETCH when discard reaches 0. ABORT → FETCH after exactly one cycle.

## Timing
- Ack in cycle n: word visible at `pf2ir_*` in n+1 if the FIFO was empty.
- Redirect in cycle n:
  - Without the abort macro: `stb` with the target address in n+1.
  - With the abort macro: `cyc` = 0 in n+1, `stb` with the target in n+2.
- Err in cycle n: `buserr` pulse and `cyc` = 0 in n+1.
- Reset release: first `stb` (`RST_ADR`) in the first clock after deassertion.
- Reset mid-transfer: all state clears asynchronously. Responses arriving after reset for earlier requests are not tracked; the bus fabric must terminate the cycle when `cyc` falls.
- Sustained throughput: one word per cycle when the bus never stalls and `DEPTH` ≥ 2 + ack latency.

## Configuration
`N1_PF_ABORT_EN`

Defined:
- Redirect enters ABORT. `cyc` and `stb` are 0 for one cycle, which terminates the bus cycle.
- Outstanding and discard clear. Fetch resumes from the target.
- DRAIN is never entered.

Undefined:
- `cyc` stays high across the redirect.
- discard ← outstanding (minus any same-cycle response), and outstanding ← 0.
- State goes to DRAIN if discard≠0, else FETCH.
- New requests issue immediately; responses are ordered, so the first discard-count responses are dropped.

## Test plan
1. **Streaming:** `DEPTH`=4, ack one cycle after each accepted request, ready=1 → addresses 0,1,2,… issued on consecutive cycles; `pf2ir_adr_o` follows 0,1,2,… one cycle after each ack.
2. **Backpressure:** ready=0 → exactly 4 requests issued; `stb` then 0 with level=4 and outstanding=0. One pop lets exactly one new request issue.
3. **Stall:** `pbus_stall_i`=1 for 3 cycles → `adr` and `stb` held; the address increments only on the accepting cycle.
4. **Redirect to `14'h0100` with 2 outstanding:**
   - Macro undefined: state DRAIN; 2 acks dropped; first delivered word has `adr` 0x0100.
   - Macro defined: `cyc` low for one cycle, then `stb` at 0x0100.
5. **Error on the 3rd response:** `buserr` pulses once; 2 words remain readable; no `stb` until redirect; redirect to 0x0020 → state FETCH, `stb` at 0x0020.
6. **Wrap-around:** redirect to 0x3FFF, `PBUS_AW`=14 → the next addresses issued are 0x3FFF then 0x0000.
